// File: rtl/srlatch_pkg.sv
// rtl/srlatch_pkg.sv - shared encodings and constants for the SR latch driver
package srlatch_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int ERR_W       = 8;
    localparam int CNT_W       = 8;

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    typedef enum logic [1:0] {
        CMD_HOLD    = 2'b00,
        CMD_SET     = 2'b01,
        CMD_RESET   = 2'b10,
        CMD_INVALID = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_CHECK,
        ST_RESP
    } state_e;

    // Latch data pins {s, r} for a command; HOLD and INVALID drive neither.
    function automatic logic [1:0] cmd_pins(cmd_e c);
        logic [1:0] pins;
        case (c)
            CMD_SET:   pins = 2'b10;
            CMD_RESET: pins = 2'b01;
            default:   pins = 2'b00;
        endcase
        return pins;
    endfunction

endpackage

// File: rtl/srlatch_driver_sync2.sv
// rtl/srlatch_driver_sync2.sv - two-flop synchronizer for the asynchronous latch output
module sync2
    import srlatch_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // Shift the asynchronous input through the synchronizer chain.
    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/srlatch_driver.sv
// rtl/srlatch_driver.sv - sequences SET/RESET/HOLD onto an SR latch and checks its output
module srlatch_driver
    import srlatch_pkg::*;
#(
    parameter int TSETUP = 2,
    parameter int TPULSE = 3,
    parameter int THOLD  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             control,
    output logic             s,
    output logic             r,
    input  logic             q_in,
    output logic             rsp_valid,
    output logic             rsp_ok,
    output logic             rsp_q,
    output logic             rsp_illegal,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] LOAD_SETUP = CNT_W'(TSETUP - 1);
    localparam logic [CNT_W-1:0] LOAD_PULSE = CNT_W'(TPULSE - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD  = CNT_W'(THOLD - 1);
    localparam logic [CNT_W-1:0] LOAD_CHECK = CNT_W'(1);

    state_e           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    cmd_e             cmd_q, cmd_n;
    logic             exp_q, exp_n;
    logic             known_q, known_n;
    logic             sync_q;

    logic             cmd_ready_n, control_n, s_n, r_n;
    logic             rsp_valid_n, rsp_ok_n, rsp_q_n, rsp_illegal_n;
    logic [ERR_W-1:0] err_n;
    logic             exp_new, ok_new;
    logic [1:0]       pins_n;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (q_in),
        .q     (sync_q)
    );

    // Next-state, phase counter, expectation tracking and next registered outputs.
    always_comb begin
        state_n       = state;
        cnt_n         = (cnt != '0) ? cnt - 1'b1 : cnt;
        cmd_n         = cmd_q;
        exp_n         = exp_q;
        known_n       = known_q;
        rsp_ok_n      = rsp_ok;
        rsp_q_n       = rsp_q;
        rsp_illegal_n = rsp_illegal;
        err_n         = err_count;
        exp_new       = exp_q;
        ok_new        = 1'b1;

        case (state)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_n = cmd_e'(cmd);
                    if (cmd_e'(cmd) == CMD_INVALID) begin
                        state_n       = ST_RESP;
                        rsp_ok_n      = 1'b0;
                        rsp_illegal_n = 1'b1;
                        rsp_q_n       = sync_q;
                        err_n         = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
                    end else begin
                        state_n = ST_SETUP;
                        cnt_n   = LOAD_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_n = ST_PULSE;
                    cnt_n   = LOAD_PULSE;
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_n = ST_HOLD;
                    cnt_n   = LOAD_HOLD;
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_n = ST_CHECK;
                    cnt_n   = LOAD_CHECK;
                end
            end
            ST_CHECK: begin
                if (cnt == '0) begin
                    state_n = ST_RESP;
                    case (cmd_q)
                        CMD_SET:   exp_new = 1'b1;
                        CMD_RESET: exp_new = 1'b0;
                        default:   exp_new = exp_q;
                    endcase
                    // A HOLD before any SET/RESET has nothing to compare against.
                    if (cmd_q == CMD_HOLD && !known_q) begin
                        ok_new = 1'b1;
                    end else begin
                        ok_new = (sync_q == exp_new);
                    end
                    exp_n         = exp_new;
                    known_n       = known_q | (cmd_q != CMD_HOLD);
                    rsp_ok_n      = ok_new;
                    rsp_q_n       = sync_q;
                    rsp_illegal_n = 1'b0;
                    if (!ok_new) begin
                        err_n = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;
                    end
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Outputs are a function of the state being entered so they can be registered.
        pins_n      = cmd_pins(cmd_n);
        cmd_ready_n = (state_n == ST_IDLE);
        control_n   = (state_n == ST_PULSE);
        rsp_valid_n = (state_n == ST_RESP);
        if (state_n == ST_SETUP || state_n == ST_PULSE || state_n == ST_HOLD) begin
            s_n = pins_n[1];
            r_n = pins_n[0];
        end else begin
            s_n = 1'b0;
            r_n = 1'b0;
        end
    end

    // State, counter, expectation and registered outputs; reset aborts any sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            cmd_q       <= CMD_HOLD;
            exp_q       <= 1'b0;
            known_q     <= 1'b0;
            cmd_ready   <= 1'b1;
            control     <= 1'b0;
            s           <= 1'b0;
            r           <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_ok      <= 1'b0;
            rsp_q       <= 1'b0;
            rsp_illegal <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            cmd_q       <= cmd_n;
            exp_q       <= exp_n;
            known_q     <= known_n;
            cmd_ready   <= cmd_ready_n;
            control     <= control_n;
            s           <= s_n;
            r           <= r_n;
            rsp_valid   <= rsp_valid_n;
            rsp_ok      <= rsp_ok_n;
            rsp_q       <= rsp_q_n;
            rsp_illegal <= rsp_illegal_n;
            err_count   <= err_n;
        end
    end

endmodule

// File: tb/tb_srlatch_driver.sv
// tb/tb_srlatch_driver.sv - directed self-checking bench for srlatch_driver
module tb_srlatch_driver;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic       cmd_ready, control, s, r;
    logic       q_in;
    logic       rsp_valid, rsp_ok, rsp_q, rsp_illegal;
    logic [7:0] err_count;

    logic       lq = 1'b0;
    logic       stuck0 = 1'b0;

    int pass_cnt = 0;
    int total = 0;

    srlatch_driver dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .control     (control),
        .s           (s),
        .r           (r),
        .q_in        (q_in),
        .rsp_valid   (rsp_valid),
        .rsp_ok      (rsp_ok),
        .rsp_q       (rsp_q),
        .rsp_illegal (rsp_illegal),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // SR latch model: transparent while control is high, sampled mid-cycle.
    always @(negedge clk) begin
        if (control && s && !r) lq <= 1'b1;
        else if (control && r && !s) lq <= 1'b0;
    end

    assign q_in = stuck0 ? 1'b0 : lq;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one command from IDLE and wait (bounded) for its response.
    task automatic do_cmd(input logic [1:0] c, output logic ok, output logic q,
                          output logic ill, output int lat);
        cmd_valid = 1'b1;
        cmd = c;
        tick();
        cmd_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 30) begin
            tick();
            lat++;
        end
        ok = rsp_ok;
        q = rsp_q;
        ill = rsp_illegal;
        if (!rsp_valid) begin
            total++;
            $display("FAIL rsp_timeout cmd=%0d waited=%0d cycles", c, lat);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); else pass_cnt++;
        total++; if ({control, s, r} !== 3'b000) $display("FAIL reset_pins got=%b exp=000", {control, s, r}); else pass_cnt++;
        total++; if (err_count !== 8'd0) $display("FAIL reset_err got=%0d exp=0", err_count); else pass_cnt++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else pass_cnt++;
    endtask

    task automatic test_set();
        int early;
        early = 0;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        tick();                                     // k+1
        cmd_valid = 1'b0;
        total++; if ({cmd_ready, control, s, r} !== 4'b0010) $display("FAIL set_k1 got={rdy,ctl,s,r}=%b exp=0010", {cmd_ready, control, s, r}); else pass_cnt++;
        tick();                                     // k+2
        total++; if (control !== 1'b0) $display("FAIL set_k2_control got=%b exp=0", control); else pass_cnt++;
        tick();                                     // k+3
        total++; if ({control, s, r} !== 3'b110) $display("FAIL set_k3 got={ctl,s,r}=%b exp=110", {control, s, r}); else pass_cnt++;
        tick(); tick();                             // k+5
        total++; if (control !== 1'b1) $display("FAIL set_k5_control got=%b exp=1", control); else pass_cnt++;
        tick();                                     // k+6
        total++; if ({control, s, r} !== 3'b010) $display("FAIL set_k6 got={ctl,s,r}=%b exp=010", {control, s, r}); else pass_cnt++;
        tick(); tick();                             // k+8
        total++; if ({control, s, r} !== 3'b000) $display("FAIL set_k8 got={ctl,s,r}=%b exp=000", {control, s, r}); else pass_cnt++;
        tick();                                     // k+9
        if (rsp_valid) early = 1;
        total++; if (early !== 0) $display("FAIL set_early_rsp got=%0d exp=0", early); else pass_cnt++;
        tick();                                     // k+10
        total++; if ({rsp_valid, rsp_ok, rsp_q, rsp_illegal} !== 4'b1110) $display("FAIL set_rsp got={v,ok,q,ill}=%b exp=1110", {rsp_valid, rsp_ok, rsp_q, rsp_illegal}); else pass_cnt++;
        tick();                                     // k+11
        total++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL set_k11 got={v,rdy}=%b exp=01", {rsp_valid, cmd_ready}); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n;
        int gap;
        cmd_valid = 1'b1;
        cmd = 2'b10;
        tick();
        cmd = 2'b00;                                // ignored until ready again
        n = 1;
        while (!rsp_valid && n < 30) begin tick(); n++; end
        total++; if (n !== 10) $display("FAIL b2b_first_latency got=%0d exp=10", n); else pass_cnt++;
        total++; if ({rsp_valid, rsp_ok, rsp_q} !== 3'b110) $display("FAIL b2b_first_rsp got={v,ok,q}=%b exp=110", {rsp_valid, rsp_ok, rsp_q}); else pass_cnt++;
        tick();
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready_after_rsp got=%b exp=1", cmd_ready); else pass_cnt++;
        tick();
        cmd_valid = 1'b0;
        total++; if ({cmd_ready, s, r} !== 3'b000) $display("FAIL b2b_second_accept got={rdy,s,r}=%b exp=000", {cmd_ready, s, r}); else pass_cnt++;
        gap = 2;
        while (!rsp_valid && gap < 40) begin tick(); gap++; end
        total++; if (gap !== 11) $display("FAIL b2b_rsp_spacing got=%0d exp=11", gap); else pass_cnt++;
        total++; if ({rsp_valid, rsp_ok, rsp_q, rsp_illegal} !== 4'b1100) $display("FAIL b2b_second_rsp got={v,ok,q,ill}=%b exp=1100", {rsp_valid, rsp_ok, rsp_q, rsp_illegal}); else pass_cnt++;
        tick();
    endtask

    task automatic test_invalid();
        cmd_valid = 1'b1;
        cmd = 2'b11;
        tick();                                     // k+1
        cmd_valid = 1'b0;
        total++; if ({rsp_valid, rsp_ok, rsp_illegal} !== 3'b101) $display("FAIL inv_rsp got={v,ok,ill}=%b exp=101", {rsp_valid, rsp_ok, rsp_illegal}); else pass_cnt++;
        total++; if ({control, s, r, cmd_ready} !== 4'b0000) $display("FAIL inv_pins got={ctl,s,r,rdy}=%b exp=0000", {control, s, r, cmd_ready}); else pass_cnt++;
        tick();                                     // k+2
        total++; if ({cmd_ready, control, s, r} !== 4'b1000) $display("FAIL inv_k2 got={rdy,ctl,s,r}=%b exp=1000", {cmd_ready, control, s, r}); else pass_cnt++;
        total++; if (err_count !== 8'd1) $display("FAIL inv_err got=%0d exp=1", err_count); else pass_cnt++;
    endtask

    task automatic test_stuck();
        logic ok, q, ill;
        int lat;
        stuck0 = 1'b1;
        do_cmd(2'b01, ok, q, ill, lat);
        total++; if ({ok, q, ill} !== 3'b000) $display("FAIL stuck_rsp got={ok,q,ill}=%b exp=000", {ok, q, ill}); else pass_cnt++;
        total++; if (lat !== 10) $display("FAIL stuck_latency got=%0d exp=10", lat); else pass_cnt++;
        total++; if (err_count !== 8'd2) $display("FAIL stuck_err1 got=%0d exp=2", err_count); else pass_cnt++;
        for (int i = 0; i < 253; i++) do_cmd(2'b01, ok, q, ill, lat);
        total++; if (err_count !== 8'd255) $display("FAIL stuck_err_full got=%0d exp=255", err_count); else pass_cnt++;
        do_cmd(2'b01, ok, q, ill, lat);
        do_cmd(2'b01, ok, q, ill, lat);
        total++; if (ok !== 1'b0) $display("FAIL stuck_sat_ok got=%b exp=0", ok); else pass_cnt++;
        total++; if (err_count !== 8'd255) $display("FAIL stuck_err_sat got=%0d exp=255", err_count); else pass_cnt++;
        stuck0 = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic ok, q, ill;
        int lat;
        int seen;
        do_cmd(2'b10, ok, q, ill, lat);             // exp=0, known
        total++; if ({ok, q} !== 2'b10) $display("FAIL mid_pre_reset got={ok,q}=%b exp=10", {ok, q}); else pass_cnt++;
        cmd_valid = 1'b1;
        cmd = 2'b01;
        tick();                                     // k+1
        cmd_valid = 1'b0;
        tick(); tick();                             // k+3, in PULSE
        total++; if (control !== 1'b1) $display("FAIL mid_in_pulse got=%b exp=1", control); else pass_cnt++;
        reset = 1'b1;
        tick();                                     // reset sampled at this edge
        total++; if ({control, s, r} !== 3'b000) $display("FAIL mid_pins_dropped got={ctl,s,r}=%b exp=000", {control, s, r}); else pass_cnt++;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (rsp_valid) seen = 1;
            tick();
        end
        total++; if (seen !== 0) $display("FAIL mid_no_rsp got=%0d exp=0", seen); else pass_cnt++;
        total++; if ({cmd_ready, err_count} !== {1'b1, 8'd0}) $display("FAIL mid_idle got={rdy,err}=%b/%0d exp=1/0", cmd_ready, err_count); else pass_cnt++;
        // Latch now holds 1 while the stale expectation was 0: only a cleared exp_known gives ok.
        do_cmd(2'b00, ok, q, ill, lat);
        total++; if ({ok, q, ill} !== 3'b110) $display("FAIL mid_hold_after_reset got={ok,q,ill}=%b exp=110", {ok, q, ill}); else pass_cnt++;
        total++; if (err_count !== 8'd0) $display("FAIL mid_err_after_hold got=%0d exp=0", err_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_set();
        test_back_to_back();
        test_invalid();
        test_stuck();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
